regfile_wb_arbiter: RTL and testbench

// Shares the single regfile write port between NREQ writeback sources
// (index 0 ALU result, 1 data-memory load, 2 LUI/JAL link value).

---
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources,
// with a registered write port and a pending-destination scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*AW-1:0]   i_req_rd,
  input  logic [NREQ*XLEN-1:0] i_req_data,
  output logic                 o_wr_en,
  output logic [AW-1:0]        o_wr_addr,
  output logic [XLEN-1:0]      o_wr_data,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_rd,
  input  logic [AW-1:0]        i_rs1,
  input  logic [AW-1:0]        i_rs2,
  output logic                 o_stall
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  logic [PW-1:0]   r_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [NREG-1:0] r_busy;

  logic [NREG-1:0] w_busy_nxt;
  logic [NREQ-1:0] w_ready;
  logic            w_any;
  logic [PW-1:0]   w_gnt;
  logic [PW:0]     w_j;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [PW-1:0]   w_ptr_nxt;

  // Scan from the pointer upward with wrap; the first valid requester wins.
  always_comb begin
    w_ready    = '0;
    w_any      = 1'b0;
    w_gnt      = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    w_j        = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_j >= (PW+1)'(NREQ)) w_j = w_j - (PW+1)'(NREQ);
      if (!w_any && i_req_valid[w_j]) begin
        w_any        = 1'b1;
        w_gnt        = w_j[PW-1:0];
        w_ready[w_j] = 1'b1;
        w_sel_rd     = i_req_rd[int'(w_j)*AW +: AW];
        w_sel_data   = i_req_data[int'(w_j)*XLEN +: XLEN];
      end
    end
    if (i_reset) begin
      w_ready = '0;
      w_any   = 1'b0;
    end
  end

  assign w_ptr_nxt = (w_gnt == PW'(NREQ-1)) ? '0 : w_gnt + PW'(1);

  // A new producer issued in the same cycle as the retiring write keeps the reg busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en) w_busy_nxt[r_wr_addr] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) w_busy_nxt[i_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_any) begin
        r_ptr   <= w_ptr_nxt;
        r_wr_en <= (w_sel_rd != '0);
        if (w_sel_rd != '0) begin
          r_wr_addr <= w_sel_rd;
          r_wr_data <= w_sel_data;
        end
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_stall     = ((i_rs1 != '0) && r_busy[i_rs1]) || ((i_rs2 != '0) && r_busy[i_rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: arbitration order, write port timing,
// x0 suppression, scoreboard stalls and reset behaviour.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        rs1;
  logic [AW-1:0]        rs2;
  logic                 stall;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_rd     (req_rd),
    .i_req_data   (req_data),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes at posedge+1; combinational checks one more unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    req_rd[idx*AW +: AW]       = rd;
    req_data[idx*XLEN +: XLEN] = data;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req_valid   = 3'b111;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
    set_req(0, 5'd1, 32'h1);
    step();
    step();
    #1;
    n_tests++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    n_tests++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wrport: got en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
    end
    req_valid = '0;
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_tests++;
      if (req_ready !== 3'b000 || wr_en !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got ready=%b wr_en=%b stall=%b want 000/0/0", c, req_ready, wr_en, stall);
      end
    end
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'h0000_0001);
    req_valid = 3'b001;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 001", req_ready);
    end
    step();
    req_valid = '0;
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h1) begin
      n_fail++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h want 1/5/00000001", wr_en, wr_addr, wr_data);
    end
    step();
    n_tests++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'h1) begin
      n_fail++;
      $display("FAIL single_hold: got en=%b addr=%0d data=%h want 0/5/00000001", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_gnt [6];
    logic [AW-1:0]   exp_rd  [6];
    logic [XLEN-1:0] exp_dat [6];
    int              pulses;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    exp_dat = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30};
    pulses  = 0;
    do_reset();
    set_req(0, 5'd1, 32'h10);
    set_req(1, 5'd2, 32'h20);
    set_req(2, 5'd3, 32'h30);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if (req_ready !== exp_gnt[c]) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got %b want %b", c, req_ready, exp_gnt[c]);
      end
      if (c > 0) begin
        if (wr_en === 1'b1) pulses++;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== exp_rd[c-1] || wr_data !== exp_dat[c-1]) begin
          n_fail++;
          $display("FAIL fair_write%0d: got en=%b addr=%0d data=%h want 1/%0d/%h",
                   c, wr_en, wr_addr, wr_data, exp_rd[c-1], exp_dat[c-1]);
        end
      end
      step();
    end
    req_valid = '0;
    if (wr_en === 1'b1) pulses++;
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h30) begin
      n_fail++;
      $display("FAIL fair_last_write: got en=%b addr=%0d data=%h want 1/3/00000030", wr_en, wr_addr, wr_data);
    end
    n_tests++;
    if (pulses != 6) begin
      n_fail++;
      $display("FAIL fair_pulses: got %0d want 6", pulses);
    end
    step();
  endtask

  task automatic test_x0();
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL x0_ready: got %b want 010", req_ready);
    end
    step();
    req_valid = '0;
    n_tests++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd3 || wr_data !== 32'h30) begin
      n_fail++;
      $display("FAIL x0_nowrite: got en=%b addr=%0d data=%h want 0/3/00000030", wr_en, wr_addr, wr_data);
    end
    set_req(1, 5'd2, 32'h20);
    req_valid = 3'b111;
    #1;
    n_tests++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL x0_ptr_adv: got %b want 100", req_ready);
    end
    step();
    req_valid = '0;
    step();
  endtask

  task automatic test_hazard();
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    rs1         = 5'd3;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL haz_pre_issue: got %b want 0", stall);
    end
    step();
    issue_valid = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL haz_set: got %b want 1", stall);
    end
    set_req(0, 5'd3, 32'hAB);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    #1;
    n_tests++;
    if (wr_en !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL haz_during_write: got en=%b stall=%b want 1/1", wr_en, stall);
    end
    step();
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL haz_cleared: got %b want 0", stall);
    end
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    step();
    issue_valid = 1'b0;
    req_valid   = 3'b001;
    step();
    req_valid   = '0;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    #1;
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL haz_clear_write: got en=%b addr=%0d want 1/3", wr_en, wr_addr);
    end
    step();
    issue_valid = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL haz_set_wins: got %b want 1", stall);
    end
    rs1 = 5'd0;
    rs2 = 5'd3;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL haz_rs2: got %b want 1", stall);
    end
    rs2 = 5'd4;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL haz_other_reg: got %b want 0", stall);
    end
  endtask

  task automatic test_reset_mid();
    rs1         = 5'd7;
    rs2         = 5'd0;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    set_req(1, 5'd9, 32'h55);
    req_valid = 3'b010;
    step();
    issue_valid = 1'b0;
    req_valid   = '0;
    reset       = 1'b1;
    #1;
    n_tests++;
    if (wr_en !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got en=%b stall=%b want 1/1", wr_en, stall);
    end
    step();
    reset = 1'b0;
    #1;
    n_tests++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: got en=%b addr=%0d stall=%b want 0/0/0", wr_en, wr_addr, stall);
    end
    req_valid = 3'b111;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_ptr: got %b want 001", req_ready);
    end
    step();
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
